lp_notch_bank: RTL and testbench

//  Generalised notch/low-pass shaper: NSEC parallel single complex-pole sections, one input stream, outputs summed and saturated.

---
 rtl/lp_notch_pkg.sv | 38 +++
 rtl/lp_pole_section.sv | 70 +++++++
 rtl/lp_notch_bank.sv | 191 +++++++++++++++++++
 tb/tb_lp_notch_bank.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_notch_pkg.sv
// Shared definitions for the lp_notch_bank shaper: coefficient select
// encodings, Q-format shift helper and a generic saturation function.
package lp_notch_pkg;

  // Low two bits of cw_addr pick which coefficient of a section is written.
  typedef enum logic [1:0] {
    SEL_AR = 2'd0,
    SEL_AI = 2'd1,
    SEL_BR = 2'd2,
    SEL_BI = 2'd3
  } coef_sel_e;

  // Coefficients are Q2.(CW-2): two integer bits, the rest fractional.
  localparam int COEF_INT_BITS = 2;

  // Right-shift that brings a coefficient product back to state scale.
  function automatic int qshift(input int cw);
    return cw - COEF_INT_BITS;
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // True when saturate() would have altered the value.
  function automatic logic clipped(input logic signed [63:0] v, input int w);
    return saturate(v, w) != v;
  endfunction

endpackage

// File: rtl/lp_pole_section.sv
// One complex single-pole section: z[n] = a*z[n-1] + b*x[n].
// Holds its own active coefficients, loaded from the top's shadow file.
module lp_pole_section
  import lp_notch_pkg::*;
#(
  parameter int CW = 18,
  parameter int DW = 18,
  parameter int SW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic signed [CW-1:0] ar_new,
  input  logic signed [CW-1:0] ai_new,
  input  logic signed [CW-1:0] br_new,
  input  logic signed [CW-1:0] bi_new,
  input  logic                 go,
  input  logic signed [DW-1:0] xr,
  input  logic signed [DW-1:0] xi,
  output logic signed [SW-1:0] zr,
  output logic signed [SW-1:0] zi
);

  // Wide enough for the sum of four full-precision products.
  localparam int PW = CW + ((SW > DW) ? SW : DW) + 2;
  localparam int QS = qshift(CW);

  logic signed [CW-1:0] ar, ai, br, bi;
  logic signed [PW-1:0] acc_r, acc_i;
  logic signed [PW-1:0] shf_r, shf_i;
  logic signed [SW-1:0] nxt_r, nxt_i;

  // Complex multiply-accumulate, floor shift, clamp to state width.
  always_comb begin
    acc_r = PW'(ar) * PW'(zr) - PW'(ai) * PW'(zi)
          + PW'(br) * PW'(xr) - PW'(bi) * PW'(xi);
    acc_i = PW'(ar) * PW'(zi) + PW'(ai) * PW'(zr)
          + PW'(br) * PW'(xi) + PW'(bi) * PW'(xr);
    shf_r = acc_r >>> QS;
    shf_i = acc_i >>> QS;
    nxt_r = SW'(saturate(64'(shf_r), SW));
    nxt_i = SW'(saturate(64'(shf_i), SW));
  end

  // Active coefficient load and state update on each completed pair.
  always_ff @(posedge clk) begin
    // NOTE: registers take <= so every flop samples pre-edge values; blocking
    // here would let zi's update see the new zr within the same edge.
    if (rst) begin
      ar <= '0;
      ai <= '0;
      br <= '0;
      bi <= '0;
      zr <= '0;
      zi <= '0;
    end else begin
      if (load) begin
        ar <= ar_new;
        ai <= ai_new;
        br <= br_new;
        bi <= bi_new;
      end
      if (go) begin
        zr <= nxt_r;
        zi <= nxt_i;
      end
    end
  end

endmodule

// File: rtl/lp_notch_bank.sv
// Bank of NSEC parallel complex-pole sections fed by one interleaved I/Q
// stream; section outputs are summed, saturated and re-interleaved.
// Coefficients go through a shadow file and are committed on an I cycle.
module lp_notch_bank
  import lp_notch_pkg::*;
#(
  parameter int NSEC = 2,
  parameter int DW   = 18,
  parameter int CW   = 18,
  parameter int SW   = 20,
  parameter int OW   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iq,
  input  logic signed [DW-1:0]      x,
  output logic signed [OW-1:0]      y,
  output logic                      y_iq,
  input  logic                      cw_we,
  input  logic [$clog2(NSEC)+1:0]   cw_addr,
  input  logic signed [CW-1:0]      cw_data,
  input  logic                      commit,
  output logic                      sat_flag,
  output logic                      seq_err
);

  localparam int AW   = $clog2(NSEC) + 2;
  localparam int SUMW = SW + $clog2(NSEC);

  // Input pairing
  logic signed [DW-1:0] held_i;
  logic                 held_v;
  logic signed [DW-1:0] pair_r, pair_i;
  logic                 go;
  logic                 seq_drop;

  // Coefficient shadow file and commit control
  logic signed [CW-1:0] sh_q   [NSEC][4];
  logic signed [CW-1:0] sh_nxt [NSEC][4];
  logic [AW-1:0]        sec_sh;
  coef_sel_e            sel;
  logic                 pending;
  logic                 load;

  // Section outputs and summation pipeline
  logic signed [SW-1:0]   zr_a [NSEC];
  logic signed [SW-1:0]   zi_a [NSEC];
  logic signed [SUMW-1:0] sum_r, sum_i;
  logic signed [OW-1:0]   sat_r, sat_i;
  logic                   clip_r, clip_i;
  logic signed [OW-1:0]   sum_re_q, sum_im_q;
  logic                   go_d, out_v, im_pend;

  // A Q sample with no held I is dropped and flagged.
  assign seq_drop = !iq && !held_v;

  // Commit lands on an I cycle; a commit raised on that same cycle counts.
  assign load = iq && (pending || commit);

  // Shadow file next-state; the write is visible to a same-cycle copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sh_nxt = sh_q;
    sel    = coef_sel_e'(cw_addr[1:0]);
    sec_sh = cw_addr >> 2;
    if (cw_we) begin
      for (int k = 0; k < NSEC; k++) begin
        if (sec_sh == AW'(k)) sh_nxt[k][sel] = cw_data;
      end
    end
  end

  // Shadow register file.
  always_ff @(posedge clk) begin
    // NOTE: the shadow file is a handful of flops, not RAM, and a defined
    // all-zero reset keeps sections disabled until software commits.
    if (rst) begin
      for (int k = 0; k < NSEC; k++) begin
        for (int s = 0; s < 4; s++) sh_q[k][s] <= '0;
      end
    end else begin
      sh_q <= sh_nxt;
    end
  end

  // I/Q pairing: hold the latest I, launch the pair on the following Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_i <= '0;
      held_v <= 1'b0;
      pair_r <= '0;
      pair_i <= '0;
      go     <= 1'b0;
    end else begin
      go <= 1'b0;
      if (iq) begin
        held_i <= x;
        held_v <= 1'b1;
      end else if (held_v) begin
        pair_r <= held_i;
        pair_i <= x;
        go     <= 1'b1;
        held_v <= 1'b0;
      end
    end
  end

  // Pending commit and sticky status flags; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      sat_flag <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      if (load)        pending <= 1'b0;
      else if (commit) pending <= 1'b1;
      if (commit) begin
        sat_flag <= 1'b0;
        seq_err  <= 1'b0;
      end
      if (go_d && (clip_r || clip_i)) sat_flag <= 1'b1;
      if (seq_drop)                   seq_err  <= 1'b1;
    end
  end

  for (genvar k = 0; k < NSEC; k++) begin : g_sec
    lp_pole_section #(
      .CW (CW),
      .DW (DW),
      .SW (SW)
    ) u_sec (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .ar_new (sh_nxt[k][SEL_AR]),
      .ai_new (sh_nxt[k][SEL_AI]),
      .br_new (sh_nxt[k][SEL_BR]),
      .bi_new (sh_nxt[k][SEL_BI]),
      .go     (go),
      .xr     (pair_r),
      .xi     (pair_i),
      .zr     (zr_a[k]),
      .zi     (zi_a[k])
    );
  end

  // Sign-extended sum of all sections, clamped to the output width.
  always_comb begin
    sum_r = '0;
    sum_i = '0;
    for (int k = 0; k < NSEC; k++) begin
      sum_r = sum_r + SUMW'(zr_a[k]);
      sum_i = sum_i + SUMW'(zi_a[k]);
    end
    clip_r = clipped(64'(sum_r), OW);
    clip_i = clipped(64'(sum_i), OW);
    sat_r  = OW'(saturate(64'(sum_r), OW));
    sat_i  = OW'(saturate(64'(sum_i), OW));
  end

  // Register the sum one cycle after the state update, then emit Re then Im.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_d     <= 1'b0;
      out_v    <= 1'b0;
      im_pend  <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      y        <= '0;
      y_iq     <= 1'b0;
    end else begin
      go_d    <= go;
      out_v   <= go_d;
      y_iq    <= 1'b0;
      im_pend <= 1'b0;
      if (go_d) begin
        sum_re_q <= sat_r;
        sum_im_q <= sat_i;
      end
      if (out_v) begin
        y       <= sum_re_q;
        y_iq    <= 1'b1;
        im_pend <= 1'b1;
      end else if (im_pend) begin
        y <= sum_im_q;
      end
    end
  end

endmodule

// File: tb/tb_lp_notch_bank.sv
// Scoreboard bench for lp_notch_bank: a cycle-level behavioural model of the
// pairing, shadow/commit and section arithmetic pushes expected output pairs,
// and a monitor on the falling edge pops and compares them.
module tb_lp_notch_bank;

  localparam int NSEC = 2;
  localparam int DW   = 18;
  localparam int CW   = 18;
  localparam int SW   = 20;
  localparam int OW   = 20;
  localparam int AW   = 3;
  localparam int QS   = CW - 2;

  logic                 clk;
  logic                 rst;
  logic                 iq;
  logic signed [DW-1:0] x;
  logic signed [OW-1:0] y;
  logic                 y_iq;
  logic                 cw_we;
  logic [AW-1:0]        cw_addr;
  logic signed [CW-1:0] cw_data;
  logic                 commit;
  logic                 sat_flag;
  logic                 seq_err;

  lp_notch_bank #(
    .NSEC (NSEC),
    .DW   (DW),
    .CW   (CW),
    .SW   (SW),
    .OW   (OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iq       (iq),
    .x        (x),
    .y        (y),
    .y_iq     (y_iq),
    .cw_we    (cw_we),
    .cw_addr  (cw_addr),
    .cw_data  (cw_data),
    .commit   (commit),
    .sat_flag (sat_flag),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     vectors;
  int     miscompares;
  int     cyc;

  // Model state
  longint m_zr  [NSEC];
  longint m_zi  [NSEC];
  longint m_sh  [NSEC][4];
  longint m_act [NSEC][4];
  bit     m_pend;
  bit     m_hv;
  longint m_held;

  always @(posedge clk) cyc = cyc + 1;

  function automatic longint bsat(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NSEC; k++) begin
      m_zr[k] = 0;
      m_zi[k] = 0;
      for (int s = 0; s < 4; s++) begin
        m_sh[k][s]  = 0;
        m_act[k][s] = 0;
      end
    end
    m_pend = 0;
    m_hv   = 0;
    m_held = 0;
    sb.delete();
  endtask

  // Apply a completed pair to the model and queue the expected output.
  task automatic model_pair(input longint xr, input longint xi);
    longint pr, pi, sr, si;
    exp_t   e;
    sr = 0;
    si = 0;
    for (int k = 0; k < NSEC; k++) begin
      pr = m_act[k][0] * m_zr[k] - m_act[k][1] * m_zi[k]
         + m_act[k][2] * xr      - m_act[k][3] * xi;
      pi = m_act[k][0] * m_zi[k] + m_act[k][1] * m_zr[k]
         + m_act[k][2] * xi      + m_act[k][3] * xr;
      m_zr[k] = bsat(pr >>> QS, SW);
      m_zi[k] = bsat(pi >>> QS, SW);
      sr += m_zr[k];
      si += m_zi[k];
    end
    e.re  = bsat(sr, OW);
    e.im  = bsat(si, OW);
    e.cyc = cyc + 4;
    sb.push_back(e);
  endtask

  // Drive one clock cycle of inputs and advance the model with it.
  task automatic step(input bit iv, input longint xv, input bit we = 1'b0,
                      input int addr = 0, input longint data = 0,
                      input bit cm = 1'b0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    iq      = iv;
    x       = DW'(xv);
    cw_we   = we;
    cw_addr = AW'(addr);
    cw_data = CW'(data);
    commit  = cm;
    if (we && (addr >> 2) < NSEC) m_sh[addr >> 2][addr & 3] = data;
    if (cm) m_pend = 1;
    if (iv) begin
      m_held = xv;
      m_hv   = 1;
      if (m_pend) begin
        m_act  = m_sh;
        m_pend = 0;
      end
    end else if (m_hv) begin
      model_pair(m_held, xv);
      m_hv = 0;
    end
  endtask

  task automatic pair(input longint xr, input longint xi);
    step(1'b1, xr);
    step(1'b0, xi);
  endtask

  task automatic wcoef(input int sec, input int sel, input longint v);
    step(1'b1, 0, 1'b1, sec * 4 + sel, v);
  endtask

  task automatic do_commit();
    step(1'b1, 0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 0);
  endtask

  // Reset asserted for one cycle; the caller's next step releases it.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    iq      = 1'b0;
    x       = '0;
    cw_we   = 1'b0;
    cw_addr = '0;
    cw_data = '0;
    commit  = 1'b0;
    model_reset();
  endtask

  // Idle on I cycles until every queued output has been seen (bounded).
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || exp_im) && n < 60) begin
      step(1'b1, 0);
      n++;
    end
    if (sb.size() != 0 || exp_im) begin
      vectors++;
      miscompares++;
      $display("FAIL %s drain: %0d outputs outstanding after %0d cycles, required 0",
               name, sb.size(), n);
      sb.delete();
    end
    step(1'b1, 0);
    step(1'b1, 0);
  endtask

  task automatic check_flags(input string name, input bit sat_e, input bit seq_e);
    vectors++;
    if (sat_flag !== sat_e) begin
      miscompares++;
      $display("FAIL %s sat_flag: got %b required %b", name, sat_flag, sat_e);
    end
    vectors++;
    if (seq_err !== seq_e) begin
      miscompares++;
      $display("FAIL %s seq_err: got %b required %b", name, seq_err, seq_e);
    end
  endtask

  // Output monitor: compare each Re/Im against the scoreboard head and
  // confirm y holds with y_iq=0 between outputs.
  bit     exp_im;
  longint exp_im_v;
  longint last_y;
  exp_t   mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_im = 0;
      last_y = 0;
    end else if (exp_im) begin
      vectors++;
      if (y_iq !== 1'b0 || y !== OW'(exp_im_v)) begin
        miscompares++;
        $display("FAIL y_im @%0d: got y=%0d y_iq=%b required y=%0d y_iq=0",
                 cyc, y, y_iq, exp_im_v);
      end
      last_y = exp_im_v;
      exp_im = 0;
    end else if (y_iq === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL y_re @%0d: unexpected output y=%0d, required none", cyc, y);
      end else begin
        mon_e = sb.pop_front();
        if (y !== OW'(mon_e.re) || mon_e.cyc != cyc) begin
          miscompares++;
          $display("FAIL y_re: got y=%0d at cycle %0d required y=%0d at cycle %0d",
                   y, cyc, mon_e.re, mon_e.cyc);
        end
        exp_im   = 1;
        exp_im_v = mon_e.im;
        last_y   = mon_e.re;
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL y_re @%0d: missing output, y_iq=%b required 1 (y=%0d)",
               cyc, y_iq, sb[0].re);
      void'(sb.pop_front());
    end else begin
      vectors++;
      if (y !== OW'(last_y)) begin
        miscompares++;
        $display("FAIL y_hold @%0d: got %0d required %0d", cyc, y, last_y);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    step(1'b1, 0);
    vectors++;
    if (y !== '0 || y_iq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_y: got y=%0d y_iq=%b required 0 0", y, y_iq);
    end
    check_flags("reset", 1'b0, 1'b0);
    // Zero coefficients after reset: any input yields zero output.
    pair(5000, -3000);
    drain("reset_zero");
  endtask

  task automatic test_impulse();
    do_reset();
    wcoef(0, 0, 32768);
    wcoef(0, 2, 65536);
    do_commit();
    pair(1000, 0);
    for (int i = 0; i < 5; i++) pair(0, 0);
    drain("impulse");
  endtask

  task automatic test_rotation();
    do_reset();
    wcoef(0, 1, 32768);
    wcoef(0, 2, 65536);
    do_commit();
    pair(1000, 0);
    for (int i = 0; i < 3; i++) pair(0, 0);
    drain("rotation");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < NSEC; k++) begin
      wcoef(k, 2, 130417);
      wcoef(k, 3, -130417);
    end
    do_commit();
    pair(131071, 131071);
    drain("saturation");
    check_flags("sat_set", 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 0);
    check_flags("sat_clear", 1'b0, 1'b0);
  endtask

  task automatic test_commit_timing();
    do_reset();
    wcoef(0, 2, 65536);
    do_commit();
    pair(1000, 0);
    wcoef(0, 2, 32768);
    // Commit on a Q cycle: this pair keeps b=1, the next uses b=0.5.
    step(1'b1, 400);
    step(1'b0, 0, 1'b0, 0, 0, 1'b1);
    pair(400, 0);
    // Write and commit together on a Q cycle: new b=0.25 from the next pair.
    step(1'b1, 400);
    step(1'b0, 0, 1'b1, 2, 16384, 1'b1);
    pair(400, 0);
    drain("commit_timing");
  endtask

  task automatic test_back_to_back();
    do_reset();
    wcoef(0, 0, -16384);
    wcoef(0, 2, 65536);
    wcoef(1, 1, 49152);
    wcoef(1, 3, 32768);
    do_commit();
    for (int i = 0; i < 8; i++)
      pair(longint'($urandom_range(40000)) - 20000,
           longint'($urandom_range(40000)) - 20000);
    drain("back_to_back");
  endtask

  task automatic test_sequencing();
    do_reset();
    wcoef(0, 2, 65536);
    do_commit();
    pair(0, 0);
    check_flags("seq_before", 1'b0, 1'b0);
    step(1'b0, 111);
    step(1'b0, 222);
    step(1'b1, 300);
    step(1'b1, 500);
    step(1'b0, -70);
    drain("sequencing");
    check_flags("seq_after", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    wcoef(0, 0, 32768);
    wcoef(0, 2, 65536);
    do_commit();
    pair(1000, 0);
    step(1'b0, 5);
    step(1'b1, 777);
    do_reset();
    step(1'b1, 0);
    vectors++;
    if (y !== '0 || y_iq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_y: got y=%0d y_iq=%b required 0 0", y, y_iq);
    end
    check_flags("reset_mid", 1'b0, 1'b0);
    pair(1000, 500);
    pair(0, 0);
    drain("reset_mid_after");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    exp_im      = 0;
    last_y      = 0;
    rst         = 1'b1;
    iq          = 1'b0;
    x           = '0;
    cw_we       = 1'b0;
    cw_addr     = '0;
    cw_data     = '0;
    commit      = 1'b0;
    model_reset();

    test_reset();
    test_impulse();
    test_rotation();
    test_saturation();
    test_commit_timing();
    test_back_to_back();
    test_sequencing();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
